// File: rtl/wb_trace_fifo.sv
// Captures CPU register writebacks (addr/data/pc) into a first-word fall-through FIFO with commit/drop counters.
// An entry is visible one edge after it is pushed; a push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic [31:0]   wb_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_addr,
  output logic [31:0]   out_data,
  output logic [31:0]   out_pc,
  output logic [AW:0]   level,
  output logic [31:0]   commit_cnt,
  output logic [15:0]   drop_cnt,
  output logic          overflow
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign push_req  = wb_en && (wb_addr != 5'd0);
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok   = push_req && ((level != FULL_LVL) || pop);
  assign drop      = push_req && !push_ok;

  assign out_addr = mem[rd_ptr].addr;
  assign out_data = mem[rd_ptr].data;
  assign out_pc   = mem[rd_ptr].pc;

  // Storage is reset so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !clr) begin
      mem[wr_ptr] <= '{addr: wb_addr, data: wb_data, pc: wb_pc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      commit_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      commit_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (push_req) commit_cnt <= commit_cnt + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized scoreboard bench for wb_trace_fifo: a queue-based reference model predicts contents and counters.
module tb_wb_trace_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst, clr, wb_en, out_ready;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data, wb_pc;
  logic          out_valid, overflow;
  logic [4:0]    out_addr;
  logic [31:0]   out_data, out_pc, commit_cnt;
  logic [AW:0]   level;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_pc(out_pc),
    .level(level), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_commit;
  logic [15:0] m_drop;
  logic        m_ovf;
  logic [4:0]  dut_last_addr;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and monitor: checks the state left by the last edge, then predicts the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_commit = '0;
      m_drop   = '0;
      m_ovf    = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("commit_cnt", 64'(commit_cnt), 64'(m_commit));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_addr", 64'(out_addr), 64'(exp_q[0].a));
        chk("out_data", 64'(out_data), 64'(exp_q[0].d));
        chk("out_pc", 64'(out_pc), 64'(exp_q[0].p));
        if (out_ready) dut_last_addr = out_addr;
      end
      if (clr) begin
        exp_q.delete();
        m_commit = '0;
        m_drop   = '0;
        m_ovf    = 1'b0;
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (wb_en && wb_addr != 5'd0) begin
          m_commit = m_commit + 32'd1;
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back('{a: wb_addr, d: wb_data, p: wb_pc});
          end else begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  task automatic step(input logic en, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] p, input logic rdy, input logic c);
    wb_en = en; wb_addr = a; wb_data = d; wb_pc = p; out_ready = rdy; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [4:0] ra;
    rst = 1'b0; clr = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0; out_ready = 1'b0;
    dut_last_addr = '0;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_commit", 64'(commit_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    step(1'b1, 5'd5, 32'h0000_00AA, 32'h0000_0010, 1'b0, 1'b0);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_addr", 64'(out_addr), 64'd5);
    chk("basic_data", 64'(out_data), 64'hAA);
    chk("basic_pc", 64'(out_pc), 64'h10);
    chk("basic_level", 64'(level), 64'd1);
    chk("basic_commit", 64'(commit_cnt), 64'd1);
    idle(1'b1);
    chk("basic_pop_valid", 64'(out_valid), 64'd0);
    chk("basic_pop_level", 64'(level), 64'd0);

    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 32'hDEAD_BEEF, 32'h40, 1'b1, 1'b0);
    chk("r0_level", 64'(level), 64'd0);
    chk("r0_commit", 64'(commit_cnt), 64'd0);
    chk("r0_valid", 64'(out_valid), 64'd0);

    for (int i = 1; i <= 18; i++) step(1'b1, 5'(i), 32'(i), 32'(i * 4), 1'b0, 1'b0);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_commit", 64'(commit_cnt), 64'd18);
    chk("fill_drop", 64'(drop_cnt), 64'd2);
    chk("fill_ovf", 64'(overflow), 64'd1);

    step(1'b1, 5'd20, 32'h20, 32'h80, 1'b1, 1'b0);
    chk("fullpp_level", 64'(level), 64'd16);
    chk("fullpp_drop", 64'(drop_cnt), 64'd2);

    n = 0;
    while (out_valid && n < 40) begin idle(1'b1); n++; end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_last_addr", 64'(dut_last_addr), 64'd20);

    for (int i = 0; i < 40; i++) begin
      step(1'b1, 5'((i % 31) + 1), 32'h1000 + 32'(i), 32'h2000 + 32'(i * 4), 1'b1, 1'b0);
      chk("wrap_level_le1", 64'(level <= 1), 64'd1);
    end
    chk("wrap_drop", 64'(drop_cnt), 64'd2);
    idle(1'b1);
    chk("wrap_empty", 64'(out_valid), 64'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 3), 32'h3000 + 32'(i), 32'h400, 1'b0, 1'b0);
    chk("preclr_level", 64'(level), 64'd5);
    chk("preclr_ovf", 64'(overflow), 64'd1);
    step(1'b1, 5'd7, 32'h7777, 32'h500, 1'b1, 1'b1);
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_commit", 64'(commit_cnt), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 3; i++) step(1'b1, 5'(i + 9), 32'h9000 + 32'(i), 32'h600, 1'b0, 1'b0);
    chk("refill_level", 64'(level), 64'd3);
    wb_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    idle(1'b0);
    idle(1'b0);
    rst = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(1'($urandom_range(0, 3) != 0), ra, $urandom, $urandom,
           (i < 1000) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 149) == 0));
    end
    n = 0;
    while (out_valid && n < 40) begin idle(1'b1); n++; end
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Captures register-file writeback events from the 5-stage pipelined CPU (write address, write data, PC of the retiring instruction) into a FIFO.
- A downstream consumer drains the captured events through a valid/ready handshake.
- Acts as the receiving end of the CPU writeback port, so a bench or on-chip monitor can check architectural state changes in retirement order.
- Also keeps a commit counter, a drop counter and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock, shared with the CPU.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- clr  input  1  synchronous clear of FIFO contents, counters and flag; active high.
- wb_en  input  1  writeback-stage register write enable.
- wb_addr  input  5  writeback destination register (CPU waddrMux).
- wb_data  input  32  writeback data (CPU wdataMux).
- wb_pc  input  32  PC of the instruction in writeback.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_addr  output  5  head entry register address.
- out_data  output  32  head entry data.
- out_pc  output  32  head entry PC.
- level  output  AW+1  number of stored entries, 0..DEPTH.
- commit_cnt  output  32  count of qualifying writebacks.
- drop_cnt  output  16  count of qualifying writebacks lost to a full FIFO.
- overflow  output  1  sticky, set on any drop.

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, level=0, out_valid=0, out_addr=0, out_data=0, out_pc=0, commit_cnt=0, drop_cnt=0, overflow=0. Takes effect immediately, including mid-transfer; all stored entries are discarded.
- Qualifying write (push request): wb_en=1 and wb_addr!=0. Writes to r0 are ignored entirely; no push and no count.
- Push acceptance: accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- Rejected push: drop_cnt increments, saturating at 16'hFFFF; overflow is set; FIFO contents are unchanged.
- commit_cnt: increments on every qualifying write, accepted or dropped. Wraps from 32'hFFFFFFFF to 0.
- Pop: occurs when out_valid=1 and out_ready=1. out_ready while out_valid=0 has no effect.
- Output mode is first-word fall-through. out_addr/out_data/out_pc always show the entry at the read pointer. out_valid = (level!=0).
- Payload under stall: out_* hold stable while out_valid=1 and out_ready=0.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass from wb_* to out_*.
- Empty outputs: out_* retain their last value while out_valid=0 (don't-care to the consumer); after reset they are 0.
- Pointers wrap modulo DEPTH. level updates are +1 on push only, -1 on pop only, unchanged on push+pop.
- Simultaneous push and pop:
  - Empty: push only, since out_valid=0.
  - Full: both happen; level stays DEPTH; no drop.
  - Otherwise: both happen; level unchanged.
- clr=1 at a clock edge:
  - Resets pointers, level, commit_cnt, drop_cnt and overflow to 0, and forces out_valid=0.
  - Any push or pop in the same cycle is ignored.
  - clr takes priority over all other events; rst takes priority over clr.
- Ordering: entries leave in exactly the order accepted; no reordering, no duplication.
- Implementation: one storage array plus a registered read pointer, write pointer and level counter; no internal FSM beyond this. out_* are driven from array[rd_ptr].

Test Plan:
- Reset/basic: hold rst=0 for 2 cycles then release; push (addr=5, data=32'h0000_00AA, pc=32'h0000_0010) with out_ready=0 -> next cycle out_valid=1, out_addr=5, out_data=32'hAA, out_pc=32'h10, level=1, commit_cnt=1. Then out_ready=1 for one cycle -> out_valid=0, level=0.
- r0 filter: wb_en=1, wb_addr=0, data=32'hDEAD_BEEF for 3 cycles -> level=0, commit_cnt=0, out_valid=0.
- Fill/overflow: out_ready=0; push 18 writes with addr=1..18 and data=i -> level=16, commit_cnt=18, drop_cnt=2, overflow=1. Drain -> addr sequence 1..16, then out_valid=0.
- Full push+pop: with level=16, push addr=20 and pop in the same cycle -> level stays 16, drop_cnt unchanged. The last drained entry has addr=20.
- Wrap-around: 40 back-to-back push+pop pairs with consumer ready, data=32'h1000+i -> data received in order 32'h1000..32'h1027, level never exceeds 1, no drops.
- clr and async reset mid-operation: with level=5 and overflow=1, pulse clr -> level=0, counters=0, overflow=0. Refill to 3 entries, then drop rst low between edges -> out_valid=0 and level=0 immediately, without waiting for a clock edge.
